// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - datapath-facing bus of the CP0 exception controller
//
// Purpose: bundles every non-clock/reset signal between the multicycle MIPS
// datapath and cp0_exc_ctrl.
//
// Port summary (seen from the datapath, modport master):
//   out int_req[5:0]      level-sensitive hardware interrupt lines
//   out exc_valid         synchronous exception, held until stall drops
//   out exc_code[4:0]     ExcCode of that exception
//   out exc_pc[31:0]      PC of the faulting / interrupted instruction
//   out eret              eret executing, held until stall drops
//   out mtc0_req          mtc0 request, held until mtc0_ack
//   out mtc0_addr[4:0]    CP0 index targeted by mtc0
//   out mtc0_data[31:0]   mtc0 write data
//   in  mtc0_ack          mtc0 accepted this cycle
//   in  cp0_w             CP0 register file write enable
//   in  cp0_a[4:0]        CP0 register file write index
//   in  cp0_wd[31:0]      CP0 register file write data
//   in  stall             freeze the datapath
//   in  redirect          one-cycle PC load strobe
//   in  redirect_pc[31:0] PC to load when redirect=1
// modport slave is the same set with directions reversed (controller side).

interface cp0_exc_ctrl_if;
  logic [5:0]  int_req;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        eret;
  logic        mtc0_req;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic        mtc0_ack;
  logic        cp0_w;
  logic [4:0]  cp0_a;
  logic [31:0] cp0_wd;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output int_req, exc_valid, exc_code, exc_pc, eret,
    output mtc0_req, mtc0_addr, mtc0_data,
    input  mtc0_ack, cp0_w, cp0_a, cp0_wd, stall, redirect, redirect_pc
  );

  modport slave (
    input  int_req, exc_valid, exc_code, exc_pc, eret,
    input  mtc0_req, mtc0_addr, mtc0_data,
    output mtc0_ack, cp0_w, cp0_a, cp0_wd, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt/eret/mtc0 sequencer
//
// Purpose: sequences the CP0 register file for exception and interrupt entry,
// eret and mtc0 in the multicycle MIPS core. Owns the single CP0 write port,
// arbitrating between the CPU mtc0 path and hardware entry/exit sequences.
// Keeps shadow copies of Status (IE, EXL, IM) and EPC, and drives stall and
// PC redirect back to the datapath.
//
// Port summary:
//   i_clk    in  system clock, rising edge
//   i_reset  in  asynchronous active-low reset
//   bus      cp0_exc_ctrl_if.slave, see rtl/cp0_exc_ctrl_if.sv
//
// Entry sequence: IDLE(decide) -> W_EPC -> W_CAUSE -> W_STATUS -> JUMP -> IDLE
// Exit sequence:  IDLE(decide) -> ERET_W -> ERET_JUMP -> IDLE

module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [4:0]  STATUS_IDX = 5'd12,
  parameter logic [4:0]  CAUSE_IDX  = 5'd13,
  parameter logic [4:0]  EPC_IDX    = 5'd14
) (
  input  logic             i_clk,
  input  logic             i_reset,
  cp0_exc_ctrl_if.slave    bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] W_EPC     = 3'd1;
  localparam logic [2:0] W_CAUSE   = 3'd2;
  localparam logic [2:0] W_STATUS  = 3'd3;
  localparam logic [2:0] JUMP      = 3'd4;
  localparam logic [2:0] ERET_W    = 3'd5;
  localparam logic [2:0] ERET_JUMP = 3'd6;

  logic [2:0]  r_state;
  logic        r_ie;
  logic        r_exl;
  logic [5:0]  r_im;
  logic [31:0] r_epc_sh;
  logic [4:0]  r_code;
  logic [31:0] r_pc;

  logic [2:0]  w_next;
  logic        w_irq;
  logic        w_take_exc;
  logic        w_take_irq;
  logic        w_take_eret;
  logic        w_mtc0_go;
  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_cp0_w;
  logic [4:0]  w_cp0_a;
  logic [31:0] w_cp0_wd;
  logic        w_mtc0_ack;
  logic [31:0] w_status_set;
  logic [31:0] w_status_clr;
  logic [31:0] w_cause;

  // Interrupts are only taken when enabled and not already inside a handler.
  assign w_irq = r_ie & ~r_exl & (|(bus.int_req & r_im));

  // Status image variants written on entry (EXL=1) and eret (EXL=0).
  assign w_status_set = {16'h0000, r_im, 8'h00, 1'b1, r_ie};
  assign w_status_clr = {16'h0000, r_im, 8'h00, 1'b0, r_ie};

  // Cause takes the interrupt lines live in the W_CAUSE cycle, not at decision.
  assign w_cause = {16'h0000, bus.int_req, 3'b000, r_code, 2'b00};

  always_comb begin
    w_next        = r_state;
    w_take_exc    = 1'b0;
    w_take_irq    = 1'b0;
    w_take_eret   = 1'b0;
    w_mtc0_go     = 1'b0;
    w_stall       = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = 32'h0000_0000;
    w_cp0_w       = 1'b0;
    w_cp0_a       = 5'd0;
    w_cp0_wd      = 32'h0000_0000;
    w_mtc0_ack    = 1'b0;

    // Gating on the async reset keeps every output low while reset is held,
    // even though IDLE decisions are combinational on the inputs.
    if (i_reset) begin
      case (r_state)
        IDLE: begin
          // Fixed priority: exception > interrupt > eret > mtc0.
          // An eret with EXL=0 is not an event, so it does not block mtc0.
          if (bus.exc_valid) begin
            w_take_exc = 1'b1;
            w_stall    = 1'b1;
            w_next     = W_EPC;
          end else if (w_irq) begin
            w_take_irq = 1'b1;
            w_stall    = 1'b1;
            w_next     = W_EPC;
          end else if (bus.eret && r_exl) begin
            w_take_eret = 1'b1;
            w_stall     = 1'b1;
            w_next      = ERET_W;
          end else if (bus.mtc0_req) begin
            w_mtc0_go  = 1'b1;
            w_mtc0_ack = 1'b1;
            w_cp0_w    = 1'b1;
            w_cp0_a    = bus.mtc0_addr;
            w_cp0_wd   = bus.mtc0_data;
          end
        end
        W_EPC: begin
          w_stall  = 1'b1;
          w_cp0_w  = 1'b1;
          w_cp0_a  = EPC_IDX;
          w_cp0_wd = r_pc;
          w_next   = W_CAUSE;
        end
        W_CAUSE: begin
          w_stall  = 1'b1;
          w_cp0_w  = 1'b1;
          w_cp0_a  = CAUSE_IDX;
          w_cp0_wd = w_cause;
          w_next   = W_STATUS;
        end
        W_STATUS: begin
          w_stall  = 1'b1;
          w_cp0_w  = 1'b1;
          w_cp0_a  = STATUS_IDX;
          w_cp0_wd = w_status_set;
          w_next   = JUMP;
        end
        JUMP: begin
          w_stall       = 1'b1;
          w_redirect    = 1'b1;
          w_redirect_pc = EXC_VECTOR;
          w_next        = IDLE;
        end
        ERET_W: begin
          w_stall  = 1'b1;
          w_cp0_w  = 1'b1;
          w_cp0_a  = STATUS_IDX;
          w_cp0_wd = w_status_clr;
          w_next   = ERET_JUMP;
        end
        ERET_JUMP: begin
          w_stall       = 1'b1;
          w_redirect    = 1'b1;
          w_redirect_pc = r_epc_sh;
          w_next        = IDLE;
        end
        default: begin
          w_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= IDLE;
      r_ie     <= 1'b0;
      r_exl    <= 1'b0;
      r_im     <= 6'd0;
      r_epc_sh <= 32'h0000_0000;
      r_code   <= 5'd0;
      r_pc     <= 32'h0000_0000;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_take_exc) begin
            r_pc   <= bus.exc_pc;
            r_code <= bus.exc_code;
          end else if (w_take_irq) begin
            // Interrupts record the PC presented on exc_pc and ExcCode 0.
            r_pc   <= bus.exc_pc;
            r_code <= 5'd0;
          end else if (w_mtc0_go) begin
            // Shadows track software writes so later images and eret agree.
            if (bus.mtc0_addr == STATUS_IDX) begin
              r_ie  <= bus.mtc0_data[0];
              r_exl <= bus.mtc0_data[1];
              r_im  <= bus.mtc0_data[15:10];
            end
            if (bus.mtc0_addr == EPC_IDX) begin
              r_epc_sh <= bus.mtc0_data;
            end
          end
        end
        W_EPC:    r_epc_sh <= r_pc;
        W_STATUS: r_exl    <= 1'b1;
        ERET_W:   r_exl    <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.stall       = w_stall;
  assign bus.redirect    = w_redirect;
  assign bus.redirect_pc = w_redirect_pc;
  assign bus.cp0_w       = w_cp0_w;
  assign bus.cp0_a       = w_cp0_a;
  assign bus.cp0_wd      = w_cp0_wd;
  assign bus.mtc0_ack    = w_mtc0_ack;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed self-checking bench for cp0_exc_ctrl

module tb_cp0_exc_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  cp0_exc_ctrl_if u_if ();

  cp0_exc_ctrl u_dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares one cycle of outputs; index/data only when a write is expected,
  // redirect_pc only when a redirect is expected.
  task automatic exp_cyc(input string tag, input logic e_stall, input logic e_w,
                         input logic [4:0] e_a, input logic [31:0] e_wd,
                         input logic e_red, input logic [31:0] e_pc, input logic e_ack);
    check({tag, "_stall"}, 32'(u_if.stall), 32'(e_stall));
    check({tag, "_w"}, 32'(u_if.cp0_w), 32'(e_w));
    check({tag, "_ack"}, 32'(u_if.mtc0_ack), 32'(e_ack));
    check({tag, "_redir"}, 32'(u_if.redirect), 32'(e_red));
    if (e_w) begin
      check({tag, "_a"}, 32'(u_if.cp0_a), 32'(e_a));
      check({tag, "_wd"}, u_if.cp0_wd, e_wd);
    end
    if (e_red) check({tag, "_rpc"}, u_if.redirect_pc, e_pc);
  endtask

  // Caller has driven the triggering inputs for cycle 0.
  task automatic entry_seq(input string tag, input logic [31:0] pc,
                           input logic [31:0] cause, input logic [31:0] st);
    #1 exp_cyc({tag, "_c0"}, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(); exp_cyc({tag, "_c1"}, 1'b1, 1'b1, 5'd14, pc, 1'b0, 32'h0, 1'b0);
    tick(); exp_cyc({tag, "_c2"}, 1'b1, 1'b1, 5'd13, cause, 1'b0, 32'h0, 1'b0);
    tick(); exp_cyc({tag, "_c3"}, 1'b1, 1'b1, 5'd12, st, 1'b0, 32'h0, 1'b0);
    tick(); exp_cyc({tag, "_c4"}, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
  endtask

  task automatic idle_cyc(input string tag);
    exp_cyc(tag, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    u_if.int_req   = 6'd0;
    u_if.exc_valid = 1'b0;
    u_if.exc_code  = 5'd0;
    u_if.exc_pc    = 32'h0;
    u_if.eret      = 1'b0;
    u_if.mtc0_req  = 1'b1;
    u_if.mtc0_addr = 5'd12;
    u_if.mtc0_data = 32'hffff_ffff;
    rst_n = 1'b0;

    // Reset held with an mtc0 pending: everything must stay 0.
    #2 idle_cyc("rst_hold");
    check("rst_rpc", u_if.redirect_pc, 32'h0);
    check("rst_wd", u_if.cp0_wd, 32'h0);
    tick(); tick();
    u_if.mtc0_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // Exception aborted by reset in W_CAUSE.
    u_if.exc_valid = 1'b1; u_if.exc_code = 5'd1; u_if.exc_pc = 32'h0000_1000;
    #1 exp_cyc("abort_c0", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(); exp_cyc("abort_c1", 1'b1, 1'b1, 5'd14, 32'h0000_1000, 1'b0, 32'h0, 1'b0);
    tick(); exp_cyc("abort_c2", 1'b1, 1'b1, 5'd13, 32'h0000_0004, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0; u_if.exc_valid = 1'b0;
    #1 idle_cyc("abort_rst");
    for (int i = 0; i < 2; i++) begin tick(); idle_cyc("abort_hold"); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); idle_cyc("abort_idle"); end

    // mtc0 Status = 0x401 -> IE=1, IM[0]=1, 0-cycle ack.
    u_if.mtc0_req = 1'b1; u_if.mtc0_addr = 5'd12; u_if.mtc0_data = 32'h0000_0401;
    #1 exp_cyc("mtc0_st", 1'b0, 1'b1, 5'd12, 32'h0000_0401, 1'b0, 32'h0, 1'b1);
    tick(); u_if.mtc0_req = 1'b0;

    // Exception entry.
    u_if.exc_valid = 1'b1; u_if.exc_code = 5'd4; u_if.exc_pc = 32'h0000_3010;
    entry_seq("exc", 32'h0000_3010, 32'h0000_0010, 32'h0000_0403);
    tick(); u_if.exc_valid = 1'b0;
    #1 idle_cyc("exc_c5");

    // Clear EXL by software, then interrupt entry.
    u_if.mtc0_req = 1'b1; u_if.mtc0_addr = 5'd12; u_if.mtc0_data = 32'h0000_0401;
    #1 exp_cyc("mtc0_clr", 1'b0, 1'b1, 5'd12, 32'h0000_0401, 1'b0, 32'h0, 1'b1);
    tick(); u_if.mtc0_req = 1'b0;
    u_if.int_req = 6'b000001; u_if.exc_pc = 32'h0000_3020;
    entry_seq("irq", 32'h0000_3020, 32'h0000_0400, 32'h0000_0403);
    for (int i = 0; i < 3; i++) begin tick(); idle_cyc("irq_nonest"); end

    // eret back to 0x3020; interrupt line dropped while sequence runs.
    u_if.eret = 1'b1;
    #1 exp_cyc("eret_c0", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(); u_if.int_req = 6'd0;
    #1 exp_cyc("eret_c1", 1'b1, 1'b1, 5'd12, 32'h0000_0401, 1'b0, 32'h0, 1'b0);
    tick(); exp_cyc("eret_c2", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_3020, 1'b0);
    tick(); u_if.eret = 1'b0;
    #1 idle_cyc("eret_c3");

    // eret with EXL=0 is ignored.
    u_if.eret = 1'b1;
    #1 idle_cyc("eret_ign0");
    tick(); idle_cyc("eret_ign1");
    u_if.eret = 1'b0;

    // Priority: exception wins over eret and mtc0; mtc0 acked after return.
    u_if.exc_valid = 1'b1; u_if.exc_code = 5'd8; u_if.exc_pc = 32'h0000_5000;
    u_if.eret = 1'b1;
    u_if.mtc0_req = 1'b1; u_if.mtc0_addr = 5'd14; u_if.mtc0_data = 32'h0000_4000;
    entry_seq("prio", 32'h0000_5000, 32'h0000_0020, 32'h0000_0403);
    tick(); u_if.exc_valid = 1'b0; u_if.eret = 1'b0;
    #1 exp_cyc("prio_mtc0", 1'b0, 1'b1, 5'd14, 32'h0000_4000, 1'b0, 32'h0, 1'b1);
    tick(); u_if.mtc0_req = 1'b0;
    #1 idle_cyc("prio_idle");

    // Status = EXL only, then eret returns to the software-written EPC.
    u_if.mtc0_req = 1'b1; u_if.mtc0_addr = 5'd12; u_if.mtc0_data = 32'h0000_0002;
    #1 exp_cyc("mtc0_exl", 1'b0, 1'b1, 5'd12, 32'h0000_0002, 1'b0, 32'h0, 1'b1);
    tick(); u_if.mtc0_req = 1'b0;
    u_if.eret = 1'b1;
    #1 exp_cyc("eret2_c0", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(); exp_cyc("eret2_c1", 1'b1, 1'b1, 5'd12, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
    tick(); exp_cyc("eret2_c2", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_4000, 1'b0);
    tick(); u_if.eret = 1'b0;
    #1 idle_cyc("eret2_c3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Sequences the CP0 register file for exceptions, interrupts, eret and mtc0 in the multicycle MIPS core.
- Arbitrates the single CP0 write port between the CPU's mtc0 path and hardware exception entry and exit.
- Keeps shadow copies of Status (IE, EXL, IM) and EPC, and drives stall and PC redirect back to the datapath.

Parameters:
- EXC_VECTOR, 32'h00000080, PC loaded on exception or interrupt entry.
- STATUS_IDX, 12, CP0 index of Status.
- CAUSE_IDX, 13, CP0 index of Cause.
- EPC_IDX, 14, CP0 index of EPC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- int_req  in  6  level-sensitive hardware interrupt lines.
- exc_valid  in  1  synchronous exception from the datapath; held until stall deasserts.
- exc_code  in  5  ExcCode of that exception.
- exc_pc  in  32  PC of the faulting instruction.
- eret  in  1  eret executing; held until stall deasserts.
- mtc0_req  in  1  CPU mtc0 request; held until mtc0_ack.
- mtc0_addr  in  5  target CP0 index.
- mtc0_data  in  32  write data.
- mtc0_ack  out  1  mtc0 accepted this cycle.
- cp0_w  out  1  CP0 write enable.
- cp0_a  out  5  CP0 write index.
- cp0_wd  out  32  CP0 write data.
- stall  out  1  freeze the datapath.
- redirect  out  1  one-cycle PC load strobe.
- redirect_pc  out  32  PC to load when redirect=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; IE=0, EXL=0, IM=0, epc_sh=0, code_r=0, pc_r=0.
  - All outputs 0.
  - Reset during any state aborts the sequence; no partial redirect; no further CP0 writes.
- Status image: {16'b0, IM[5:0] at bits 15:10, 8'b0, EXL at bit 1, IE at bit 0}.
- Interrupt pending: irq = IE & ~EXL & |(int_req & IM).
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, JUMP, ERET_W, ERET_JUMP.
- IDLE arbitration, fixed priority exc_valid > irq > eret > mtc0_req:
  - exc_valid: stall=1 combinationally; latch pc_r=exc_pc, code_r=exc_code; go to W_EPC.
  - irq: stall=1; latch pc_r=exc_pc, code_r=0; go to W_EPC.
  - eret with EXL=1: stall=1; go to ERET_W.
  - eret with EXL=0: ignored; no stall, no write, no redirect.
  - mtc0_req: same cycle, cp0_w=1, cp0_a=mtc0_addr, cp0_wd=mtc0_data, mtc0_ack=1.
    - At the edge, if addr==STATUS_IDX, load IE=data[0], EXL=data[1], IM=data[15:10].
    - If addr==EPC_IDX, load epc_sh=data.
  - A lower-priority event in the same cycle gets no ack and waits.
- W_EPC:
  - cp0_w=1, cp0_a=EPC_IDX, cp0_wd=pc_r; epc_sh<=pc_r.
- W_CAUSE:
  - cp0_w=1, cp0_a=CAUSE_IDX.
  - cp0_wd={16'b0, int_req sampled this cycle at 15:10, 3'b0, code_r at 6:2, 2'b0}.
- W_STATUS:
  - cp0_w=1, cp0_a=STATUS_IDX, cp0_wd=image with EXL=1; EXL<=1.
- JUMP:
  - redirect=1, redirect_pc=EXC_VECTOR, cp0_w=0; go to IDLE.
- ERET_W:
  - cp0_w=1, cp0_a=STATUS_IDX, cp0_wd=image with EXL=0; EXL<=0.
- ERET_JUMP:
  - redirect=1, redirect_pc=epc_sh; go to IDLE.
- Stall and write rules:
  - stall=1 in the IDLE decision cycle and every non-IDLE state, including JUMP and ERET_JUMP.
  - mtc0_ack=0 outside IDLE.
  - cp0_w is never asserted by two sources in one cycle.
- Latency:
  - Exception entry: decision cycle 0, redirect in cycle 4, IDLE in cycle 5.
  - eret: redirect in cycle 2.
  - mtc0: 0-cycle ack.
- Inputs arriving outside IDLE are not sampled. Interrupts are level-sensitive and re-evaluated in IDLE; EXL=1 after entry blocks nesting.

Test Plan:
- Reset: reset=0 mid-W_CAUSE, then release.
  - Required: all outputs 0 and IDLE; no redirect; next IDLE mtc0 to 12 with 32'h0000_0401 sets IE=1, IM[0]=1.
- Exception entry: exc_valid=1, exc_code=5'd4, exc_pc=32'h0000_3010.
  - Required writes: [14]=32'h3010, then [13]=32'h0000_0010, then [12] with EXL=1.
  - Required redirect: redirect=1 with 32'h80 in cycle 4; stall=1 for cycles 0-4.
- Interrupt: IE=1, IM=6'b000001, int_req=6'b000001, exc_pc=32'h3020.
  - Required: Cause=32'h0000_0400, EPC=32'h3020, redirect to 32'h80.
  - While EXL=1, a held int_req causes no re-entry.
- eret: after the entry above, assert eret.
  - Required: Status written with EXL=0, then redirect to 32'h3020 in cycle 2.
  - eret with EXL=0: no stall, no redirect.
- Priority: exc_valid, eret and mtc0_req all asserted in one IDLE cycle.
  - Required: exception sequence runs, mtc0_ack=0 throughout.
  - mtc0 is acked on the first IDLE cycle after return, once exc_valid is dropped.
- mtc0 to EPC (14) with 32'h0000_4000, then set EXL via Status and issue eret.
  - Required: redirect_pc=32'h4000.
